// File: rtl/riscv_ascon_perm_unit.sv
// Iterative Ascon-p permutation engine: applies 0..12 rounds, UNROLL rounds per clock, valid/ready result.
// Define ASCON_ENDIAN_SWAP_EN to byte-reverse each 32-bit half of every word on load and on output.
module riscv_ascon_perm_unit #(
    parameter int UNROLL     = 1,
    parameter int MAX_ROUNDS = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [3:0]   rounds_i,
    input  logic [319:0] state_i,
    input  logic         abort_i,
    output logic         ready_o,
    output logic         busy_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [319:0] state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   roundIdx_q, roundIdx_d;
    logic [319:0] perm_q, perm_d;
    logic [3:0]   roundsEff;
    logic [4:0]   idxSum;
    logic [319:0] loadState;
    logic [319:0] roundsOut;

    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] asconRound(input logic [319:0] s, input logic [3:0] idx);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128];
        x3 = s[127:64];
        x4 = s[63:0];
        x2[7:0] = x2[7:0] ^ {~idx, idx};
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
        x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // Slots whose round index would pass 11 are bypassed, so a short final beat matches single rounds.
    function automatic logic [319:0] applyRounds(input logic [319:0] s, input logic [3:0] idx);
        logic [319:0] acc;
        logic [4:0]   slot;
        acc = s;
        for (int k = 0; k < UNROLL; k++) begin
            slot = {1'b0, idx} + 5'(k);
            if (slot < 5'd12) begin
                acc = asconRound(acc, slot[3:0]);
            end
        end
        return acc;
    endfunction

`ifdef ASCON_ENDIAN_SWAP_EN
    function automatic logic [319:0] swapHalves(input logic [319:0] s);
        logic [319:0] r;
        r = '0;
        for (int w = 0; w < 10; w++) begin
            for (int b = 0; b < 4; b++) begin
                r[w*32 + b*8 +: 8] = s[w*32 + (3-b)*8 +: 8];
            end
        end
        return r;
    endfunction

    assign loadState = swapHalves(state_i);
    assign state_o   = swapHalves(perm_q);
`else
    assign loadState = state_i;
    assign state_o   = perm_q;
`endif

    assign roundsEff = (32'(rounds_i) > MAX_ROUNDS) ? 4'(MAX_ROUNDS) : rounds_i;
    assign idxSum    = {1'b0, roundIdx_q} + 5'(UNROLL);
    assign roundsOut = applyRounds(perm_q, roundIdx_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q      <= IDLE;
            roundIdx_q <= 4'd0;
            perm_q     <= '0;
        end else begin
            fsm_q      <= fsm_d;
            roundIdx_q <= roundIdx_d;
            perm_q     <= perm_d;
        end
    end

    always_comb begin
        fsm_d      = fsm_q;
        roundIdx_d = roundIdx_q;
        perm_d     = perm_q;
        case (fsm_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    perm_d     = loadState;
                    roundIdx_d = 4'd12 - roundsEff;
                    fsm_d      = (roundsEff == 4'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort_i) begin
                    fsm_d      = IDLE;
                    perm_d     = '0;
                    roundIdx_d = 4'd0;
                end else begin
                    perm_d = roundsOut;
                    if (idxSum >= 5'd12) begin
                        roundIdx_d = 4'd12;
                        fsm_d      = DONE;
                    end else begin
                        roundIdx_d = idxSum[3:0];
                    end
                end
            end
            DONE: begin
                if (abort_i) begin
                    fsm_d      = IDLE;
                    perm_d     = '0;
                    roundIdx_d = 4'd0;
                end else if (ready_i) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign ready_o = (fsm_q == IDLE);
    assign busy_o  = (fsm_q == RUN);
    assign valid_o = (fsm_q == DONE);

endmodule
